axi_stream_rr_arbiter: RTL and testbench
========================================

// Module: axi_stream_rr_arbiter
// PURPOSE
//  Shares one 2-bit valid/ready data channel between NUM_REQ requesters (switch
//  samplers, trigger sources) ahead of the fabric master handshake stage.
//  Grants are round-robin, with up to BURST back-to-back beats per grant.
//  A registered output stage tags each beat with its source index.
// PARAMETERS
//  NUM_REQ  4  number of requesters, 2..8
//  DATA_W   2  payload width per requester
//  BURST    4  max beats per grant, 1..15
// PORTS
//  clk        in   1                clock, all logic on rising edge
//  rst        in   1                asynchronous, active-high reset
//  req_valid  in   NUM_REQ          per-requester valid
//  req_data   in   NUM_REQ*DATA_W   requester i payload at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ          per-requester ready (one-hot or zero)
//  m_valid    out  1                downstream valid (registered)
//  m_ready    in   1                downstream ready
//  m_data     out  DATA_W           downstream payload (registered)
//  m_src      out  $clog2(NUM_REQ)  index of the requester that produced m_data
//  busy       out  1                high while in GRANT
// BEHAVIOUR
//  Reset: m_valid=0, m_data=0, m_src=0, busy=0, state=IDLE, beat_cnt=0,
//  last_grant=NUM_REQ-1 (requester 0 has top priority first). req_ready is
//  combinational and 0 in reset.
//  Handshake: a beat transfers when valid && ready are high at a clock edge.
//  Upstream valid never depends on ready.
//  FSM:
//   IDLE : if |req_valid -> grant = first set bit searching from last_grant+1,
//          wrapping modulo NUM_REQ; beat_cnt=0; -> GRANT. Otherwise stay.
//   GRANT: req_ready[grant] = (!m_valid || m_ready). All other req_ready = 0.
//          On an upstream handshake: m_data<=req_data[grant], m_src<=grant,
//          m_valid<=1, beat_cnt++.
//          -> IDLE, last_grant<=grant, when either:
//           - a handshake with beat_cnt==BURST-1, or
//           - req_valid[grant]==0 (requester withdrew; no beat taken that cycle).
//  Output register: m_valid clears on m_ready && no new load in the same cycle.
//  Simultaneous drain and load keeps m_valid=1 with the new data. m_data/m_src
//  hold while m_valid && !m_ready.
//  Latency: req_valid rising in IDLE at cycle 0 -> handshake at edge 1 ->
//  m_valid=1 from cycle 2. With m_ready=1, throughput is 1 beat/cycle inside a
//  grant. Each regrant costs one IDLE cycle.
//  Boundaries:
//   - No requests: stays IDLE; m_valid still drains.
//   - Single active requester: regranted after each burst, one bubble per BURST.
//   - Downstream stall: req_ready=0 and no beat lost or duplicated. The grant
//     does not time out.
//   - Reset mid-burst: everything returns to reset values asynchronously.
//     A beat pending in the output register is dropped.
//  Width rules: beat_cnt is $clog2(BURST+1) bits; grant and m_src are
//  $clog2(NUM_REQ) bits.
// STRUCTURE
//  Shared package axi_fabric_pkg holds:
//   - typedef enum logic {ST_IDLE, ST_GRANT} arb_state_e
//   - default DATA_W constant
//  Sub-module rr_pick: combinational priority search.
//   - inputs: req vector, last_grant
//   - outputs: grant index, any_req
//  The FSM, beat counter and output register live in the top module.
// TESTING
//  1 Reset, then req_valid=4'b0001, data0=2'b10, m_ready=1 -> m_valid at cycle 2,
//    m_data=2'b10, m_src=0.
//  2 All four valid and held, m_ready=1, BURST=4 -> m_src sequence
//    0,0,0,0,1,1,1,1,2... with one bubble cycle at each grant change.
//  3 Requester 2 in GRANT, m_ready=0 for 5 cycles -> req_ready=0, m_data held
//    stable. Release -> beats resume in order with no loss or duplication.
//  4 Requester 1 drops valid after 2 beats -> IDLE. Requester 3 (also valid) is
//    granted next, not requester 1.
//  5 Assert rst mid-burst with m_valid=1 -> m_valid=0, busy=0 immediately. After
//    release, requester 0 wins when all are valid.
//  6 Scoreboard over 10k random valid/ready cycles -> per-source order kept, no
//    beat lost, every grant <= BURST beats.

Source files
------------

// File: rtl/axi_stream_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_fabric_pkg
// Shared types and constants for the stream arbiter slice.
//   arb_state_e    : arbiter FSM state encoding
//   DATA_W_DEFAULT : default payload width per requester
//   wrap_idx       : single-step modulo wrap used by the round-robin search
// ---------------------------------------------------------------------------
package axi_fabric_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEFAULT = 2;

    // idx is always below 2*n here, so one subtraction is enough.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/axi_stream_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_stream_rr_arbiter_if
// Bundles the requester-side and downstream-side handshake signals of the
// arbiter.
//   req_valid/req_data/req_ready : NUM_REQ upstream valid/ready channels
//   m_valid/m_ready/m_data/m_src : single registered downstream channel
//   busy                         : arbiter is holding a grant
// Modports:
//   master : arbiter view (drives ready, downstream data, busy)
//   slave  : environment view (drives requests and downstream ready)
// ---------------------------------------------------------------------------
interface axi_stream_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = axi_fabric_pkg::DATA_W_DEFAULT
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      m_valid;
    logic                      m_ready;
    logic [DATA_W-1:0]         m_data;
    logic [IDX_W-1:0]          m_src;
    logic                      busy;

    modport master (
        input  req_valid, req_data, m_ready,
        output req_ready, m_valid, m_data, m_src, busy
    );

    modport slave (
        output req_valid, req_data, m_ready,
        input  req_ready, m_valid, m_data, m_src, busy
    );

endinterface

// File: rtl/axi_stream_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first set request bit found
// starting one position after i_last and wrapping modulo NUM_REQ.
//   i_req   : request vector
//   i_last  : index granted most recently
//   o_grant : selected index (i_last when nothing is requesting)
//   o_any   : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
    import axi_fabric_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_any
);

    // Walk the offsets from farthest to nearest so the nearest hit after
    // i_last is the one that survives.
    always_comb begin
        o_grant = i_last;
        o_any   = |i_req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int w_idx;
            w_idx   = wrap_idx(int'(i_last) + k, NUM_REQ);
            o_grant = i_req[w_idx] ? IDX_W'(w_idx) : o_grant;
        end
    end

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_stream_rr_arbiter
// Round-robin arbiter sharing one valid/ready stream between NUM_REQ
// requesters. A grant lasts up to BURST beats or until the granted requester
// withdraws; every regrant spends one cycle in IDLE. Accepted beats land in a
// registered output stage tagged with the source index.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : axi_stream_rr_arbiter_if.master
//         req_valid/req_data in, req_ready out (combinational, one-hot or 0)
//         m_valid/m_data/m_src out (registered), m_ready in
//         busy out (high while a grant is held)
// ---------------------------------------------------------------------------
module axi_stream_rr_arbiter
    import axi_fabric_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int BURST   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_stream_rr_arbiter_if.master  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_beat_nxt;

    logic               r_m_valid;
    logic [DATA_W-1:0]  r_m_data;
    logic [IDX_W-1:0]   r_m_src;

    logic [IDX_W-1:0]   w_pick;
    logic               w_any;
    logic               w_can_load;
    logic               w_grant_valid;
    logic               w_up_hs;
    logic [DATA_W-1:0]  w_grant_data;
    logic [NUM_REQ-1:0] w_req_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign w_can_load    = !r_m_valid || bus.m_ready;
    assign w_grant_valid = bus.req_valid[r_grant];
    assign w_up_hs       = (r_state == ST_GRANT) && w_grant_valid && w_can_load;

    // Select the granted requester's payload lane.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_data = (r_grant == IDX_W'(i)) ? bus.req_data[i*DATA_W +: DATA_W]
                                                  : w_grant_data;
        end
    end

    // Only the granted requester may see ready, and only when a beat fits.
    always_comb begin
        w_req_ready = '0;
        if (r_state == ST_GRANT) begin
            w_req_ready[r_grant] = w_can_load;
        end else begin
            w_req_ready = '0;
        end
    end

    // Next-state logic for grant selection, burst counting and release.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_pick;
                    w_beat_nxt  = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!w_grant_valid) begin
                    // Withdrawal: release without taking a beat.
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_grant;
                end else if (w_up_hs) begin
                    w_beat_nxt = r_beat_cnt + CNT_W'(1);
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = r_grant;
                    end else begin
                        w_state_nxt = ST_GRANT;
                    end
                end else begin
                    // Downstream stall: hold the grant indefinitely.
                    w_state_nxt = ST_GRANT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= LAST_IDX;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_beat_cnt   <= w_beat_nxt;
        end
    end

    // Output stage: load on upstream handshake, otherwise drain on m_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_src   <= '0;
        end else if (w_up_hs) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_grant_data;
            r_m_src   <= r_grant;
        end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
        end else begin
            r_m_valid <= r_m_valid;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_data    = r_m_data;
    assign bus.m_src     = r_m_src;
    assign bus.busy      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_rr_arbiter
// Scenario tasks drive requests; step() advances one clock, records every
// upstream acceptance into a scoreboard queue and checks each downstream
// beat against it. Requester i sends payload (beat_number ^ 2'b10).
// ---------------------------------------------------------------------------
module tb_axi_stream_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 2;
    localparam int BURST   = 4;

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    axi_stream_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

    axi_stream_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .BURST   (BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    beat_t              sb_q[$];
    logic [NUM_REQ-1:0] acc = '0;
    int                 seq [NUM_REQ] = '{default: 0};
    int                 burst_cnt = 0;
    int                 n_pop = 0;

    task automatic drive_data();
        logic [1:0] d;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = 2'(seq[i]);
            bus.req_data[i*DATA_W +: DATA_W] = d ^ 2'b10;
        end
    endtask

    // One clock: observe at the falling edge, update payloads #1 after rise.
    task automatic step();
        beat_t b;
        beat_t e;
        @(negedge clk);
        acc = '0;
        if (!rst) begin
            if (!bus.busy) burst_cnt = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    acc[i] = 1'b1;
                    b.src  = 2'(i);
                    b.data = bus.req_data[i*DATA_W +: DATA_W];
                    sb_q.push_back(b);
                    burst_cnt++;
                    n_tests++;
                    if (burst_cnt > BURST) begin
                        n_fail++;
                        $display("FAIL burst_len: got %0d beats, required <= %0d", burst_cnt, BURST);
                    end
                end
            end
            n_tests++;
            if (!$onehot0(bus.req_ready)) begin
                n_fail++;
                $display("FAIL ready_onehot: got %b, required one-hot or zero", bus.req_ready);
            end
            if (bus.m_valid && bus.m_ready) begin
                n_tests++;
                n_pop++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got beat src=%0d data=%b, required none", bus.m_src, bus.m_data);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.m_src !== e.src || bus.m_data !== e.data) begin
                        n_fail++;
                        $display("FAIL sb_beat: got src=%0d data=%b, required src=%0d data=%b",
                                 bus.m_src, bus.m_data, e.src, e.data);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) seq[i] = seq[i] + 1;
        end
        drive_data();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.m_ready   = 1'b0;
        sb_q.delete();
        burst_cnt = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.m_ready   = 1'b1;
        repeat (8) step();
        n_tests++;
        if (sb_q.size() != 0 || bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got queue=%0d m_valid=%b busy=%b, required 0 0 0",
                     sb_q.size(), bus.m_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.m_ready   = 1'b0;
        drive_data();
        #2;
        n_tests++;
        if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b required 0", bus.m_valid); end
        n_tests++;
        if (bus.m_data !== 2'b00) begin n_fail++; $display("FAIL rst_m_data: got %b required 00", bus.m_data); end
        n_tests++;
        if (bus.m_src !== 2'd0) begin n_fail++; $display("FAIL rst_m_src: got %0d required 0", bus.m_src); end
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        n_tests++;
        if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b required 0000", bus.req_ready); end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_first_beat();
        bus.req_valid = 4'b0001;
        bus.m_ready   = 1'b1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_c0: got busy=%b m_valid=%b required 0 0", bus.busy, bus.m_valid);
        end
        step();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.req_ready !== 4'b0001 || bus.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_c1: got busy=%b ready=%b m_valid=%b required 1 0001 0",
                               bus.busy, bus.req_ready, bus.m_valid);
        end
        step();
        n_tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 2'b10 || bus.m_src !== 2'd0) begin
            n_fail++; $display("FAIL lat_c2: got m_valid=%b data=%b src=%0d required 1 10 0",
                               bus.m_valid, bus.m_data, bus.m_src);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int  n;
        bit  exp_v;
        do_reset();
        bus.req_valid = 4'b1111;
        bus.m_ready   = 1'b1;
        for (n = 0; n < 20 && bus.m_valid !== 1'b1; n++) step();
        n_tests++;
        if (bus.m_valid !== 1'b1) begin
            n_fail++; $display("FAIL rr_start: got m_valid=%b required 1 within 20 cycles", bus.m_valid);
        end
        for (int s = 0; s < 20; s++) begin
            exp_v = ((s % 5) != 4);
            n_tests++;
            if (bus.m_valid !== exp_v) begin
                n_fail++; $display("FAIL rr_valid[%0d]: got %b required %b", s, bus.m_valid, exp_v);
            end
            if (exp_v) begin
                n_tests++;
                if (bus.m_src !== 2'(s / 5)) begin
                    n_fail++; $display("FAIL rr_src[%0d]: got %0d required %0d", s, bus.m_src, s / 5);
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_stall();
        int         n;
        logic [1:0] exp_d;
        exp_d         = 2'(seq[2]);
        exp_d         = exp_d ^ 2'b10;
        bus.req_valid = 4'b0100;
        bus.m_ready   = 1'b0;
        for (n = 0; n < 10 && bus.m_valid !== 1'b1; n++) step();
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d || bus.m_src !== 2'd2) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b data=%b src=%0d required 1 %b 2",
                                   c, bus.m_valid, bus.m_data, bus.m_src, exp_d);
            end
            n_tests++;
            if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL stall_ready[%0d]: got ready=%b busy=%b required 0000 1",
                                   c, bus.req_ready, bus.busy);
            end
            step();
        end
        bus.m_ready = 1'b1;
        repeat (8) step();
        drain();
    endtask

    task automatic test_withdraw();
        int n;
        int cnt1 = 0;
        do_reset();
        bus.req_valid = 4'b1010;
        bus.m_ready   = 1'b1;
        for (n = 0; n < 20 && cnt1 < 2; n++) begin
            step();
            if (acc[1]) cnt1++;
        end
        bus.req_valid[1] = 1'b0;
        acc = '0;
        for (n = 0; n < 10 && acc == 4'b0000; n++) step();
        n_tests++;
        if (acc !== 4'b1000) begin
            n_fail++; $display("FAIL withdraw_next: got accept=%b required 1000", acc);
        end
        n_tests++;
        if (cnt1 != 2) begin
            n_fail++; $display("FAIL withdraw_cnt: got %0d beats from req1 required 2", cnt1);
        end
        drain();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        bus.req_valid = 4'b1111;
        bus.m_ready   = 1'b1;
        for (n = 0; n < 20 && !(bus.m_valid === 1'b1 && bus.busy === 1'b1); n++) step();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rst_mid: got m_valid=%b busy=%b ready=%b required 0 0 0000",
                               bus.m_valid, bus.busy, bus.req_ready);
        end
        n_tests++;
        if (bus.m_data !== 2'b00 || bus.m_src !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_out: got data=%b src=%0d required 00 0", bus.m_data, bus.m_src);
        end
        sb_q.delete();
        burst_cnt = 0;
        step();
        step();
        rst = 1'b0;
        acc = '0;
        for (n = 0; n < 10 && acc == 4'b0000; n++) step();
        n_tests++;
        if (acc !== 4'b0001) begin
            n_fail++; $display("FAIL rst_mid_first: got accept=%b required 0001", acc);
        end
        drain();
    endtask

    task automatic test_random();
        int pops_before;
        pops_before = n_pop;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] || acc[i])
                    bus.req_valid[i] = ($urandom_range(0, 99) < 50);
                else if ($urandom_range(0, 99) < 3)
                    bus.req_valid[i] = 1'b0;
            end
            bus.m_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        drain();
        n_tests++;
        if (n_pop - pops_before < 1000) begin
            n_fail++; $display("FAIL random_activity: got %0d beats required >= 1000", n_pop - pops_before);
        end
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_round_robin();
        test_stall();
        test_withdraw();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
